// File: rtl/conv3x3_window_mac_pkg.sv
// Shared types and arithmetic helpers for the 3x3 window MAC.
// Pixel width follows WID_FIFO; it falls back to 16 when no project header defines it.
`ifndef WID_FIFO
`define WID_FIFO 16
`endif

package conv3x3_window_mac_pkg;

    localparam int DATA_W_DEF  = `WID_FIFO;
    localparam int KERNEL_TAPS = 9;
    // Nine 2*DATA_W products need four guard bits.
    localparam int SUM_W       = 2 * DATA_W_DEF + 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef logic [KERNEL_TAPS-1:0][DATA_W_DEF-1:0] kernel_t;

    function automatic logic [DATA_W_DEF-1:0] saturate(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        hi = '0;
        hi[DATA_W_DEF-2:0] = '1;
        lo = ~hi;
        if (v > hi) return hi[DATA_W_DEF-1:0];
        if (v < lo) return lo[DATA_W_DEF-1:0];
        return v[DATA_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/conv3x3_window_mac_if.sv
// Column-in / pixel-out stream bundle of the window MAC.
// master = upstream/downstream environment, slave = the MAC.
interface conv3x3_window_mac_if
    import conv3x3_window_mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] row_new;
    logic [DATA_W-1:0] row_d1;
    logic [DATA_W-1:0] row_d2;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_valid, row_new, row_d1, row_d2, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_valid, row_new, row_d1, row_d2, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/conv3x3_adder_tree.sv
// Sums the nine registered products, rescales, saturates and registers the output pixel.
// CONV_RELU_EN clamps negative results to zero in the same stage.
module conv3x3_adder_tree
    import conv3x3_window_mac_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   in_vld,
    input  logic [KERNEL_TAPS-1:0][2*DATA_W-1:0]   prod,
    output logic [DATA_W-1:0]                      out_data,
    output logic                                   out_valid
);
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] shifted;
    logic [DATA_W-1:0]       res;
    logic [DATA_W-1:0]       out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    always_comb begin
        sum = '0;
        for (int i = 0; i < KERNEL_TAPS; i++)
            sum = sum + {{(SUM_W-2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
        shifted = sum >>> FRAC_BITS;
        res     = saturate(shifted);
`ifdef CONV_RELU_EN
        if (res[DATA_W-1]) res = '0;
`endif
        out_valid_d = en ? in_vld : out_valid_q;
        out_data_d  = (en && in_vld) ? res : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
endmodule

// File: rtl/conv3x3_window_mac.sv
// 3x3 sliding-window multiply-accumulate with frame counters and a drain-aware FSM.
// Optional macro CONV_RELU_EN enables a fused ReLU on the output stage.
module conv3x3_window_mac
    import conv3x3_window_mac_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_BITS = 8,
    parameter int DIM_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      img_width,
    input  logic [DIM_W-1:0]      img_height,
    input  logic                  wt_we,
    input  logic [3:0]            wt_addr,
    input  logic [DATA_W-1:0]     wt_data,
    conv3x3_window_mac_if.slave   p,
    output logic                  busy,
    output logic                  frame_done
);
    state_e           state_q;
    logic [DIM_W-1:0] width_q, height_q, col_q, row_q;
    logic             done_pend_q;

    kernel_t                                  kern_q, kern_d;
    logic [KERNEL_TAPS-1:0][DATA_W-1:0]       win_q, win_d;
    logic [KERNEL_TAPS-1:0][2*DATA_W-1:0]     prod_q, prod_d;
    logic [1:0]                               vld_pipe_q, vld_pipe_d;
    logic [2:0][DATA_W-1:0]                   pix;
    logic signed [DATA_W-1:0]                 mul_a, mul_b;
    logic signed [2*DATA_W-1:0]               mul_p;
    logic                                     en, accept;

    assign en         = !p.out_valid || p.out_ready;
    assign p.in_ready = en && (state_q == RUN);
    assign accept     = p.in_valid && p.in_ready;
    assign busy       = (state_q == RUN);
    // Last accepted column is always a valid window, so an empty upstream pipe marks the final output.
    assign frame_done = done_pend_q && p.out_valid && p.out_ready && (vld_pipe_q == '0);

    assign pix[0] = p.row_d2;
    assign pix[1] = p.row_d1;
    assign pix[2] = p.row_new;

    always_comb begin
        kern_d     = kern_q;
        win_d      = win_q;
        prod_d     = prod_q;
        vld_pipe_d = vld_pipe_q;
        mul_a      = '0;
        mul_b      = '0;
        mul_p      = '0;
        if (wt_we && state_q != RUN) begin
            for (int i = 0; i < KERNEL_TAPS; i++)
                if (wt_addr == 4'(i)) kern_d[i] = wt_data;
        end
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
                win_d[r*3+2] = pix[r];
            end
        end
        if (en) begin
            vld_pipe_d[0] = accept && (col_q >= DIM_W'(2)) && (row_q >= DIM_W'(2));
            vld_pipe_d[1] = vld_pipe_q[0];
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                mul_a     = win_q[i];
                mul_b     = kern_q[i];
                mul_p     = mul_a * mul_b;
                prod_d[i] = mul_p;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kern_q     <= '0;
            win_q      <= '0;
            prod_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            kern_q     <= kern_d;
            win_q      <= win_d;
            prod_q     <= prod_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            done_pend_q <= 1'b0;
        end else begin
            if (frame_done) done_pend_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        width_q  <= img_width;
                        height_q <= img_height;
                        col_q    <= '0;
                        row_q    <= '0;
                        state_q  <= RUN;
                    end else if (frame_done) begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col_q == width_q - DIM_W'(1)) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
                            if (row_q == height_q - DIM_W'(1)) begin
                                state_q     <= DONE;
                                done_pend_q <= 1'b1;
                            end
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    conv3x3_adder_tree #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_vld    (vld_pipe_q[1]),
        .prod      (prod_q),
        .out_data  (p.out_data),
        .out_valid (p.out_valid)
    );
endmodule

// File: doc/conv3x3_window_mac.md
Name: conv3x3_window_mac

Overview:
- Sits directly downstream of the two-row line shift register in the convolver.
- Each accepted column delivers three vertically aligned pixels: the current row plus the two delayed rows.
- The block builds a 3x3 sliding window, multiplies it by a loaded 3x3 signed kernel, accumulates, rescales and saturates, then emits one output pixel per valid window.
- A frame FSM with column/row counters suppresses windows that straddle row or frame edges.

Parameters:
- DATA_W, default `WID_FIFO (header.vh): pixel and weight width, signed two's complement.
- FRAC_BITS, default 8: arithmetic right-shift applied to the sum before saturation.
- DIM_W, default 10: width of the image width/height configuration and of the counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame (honoured in IDLE/DONE only).
- img_width  in  DIM_W  columns per row; legal range 3..2^DIM_W-1; sampled on start.
- img_height  in  DIM_W  rows per frame; legal range 3..2^DIM_W-1; sampled on start.
- wt_we  in  1  kernel write strobe.
- wt_addr  in  4  kernel index 0..8; index = r*3+c, where r=0 is the oldest row and c=0 is the oldest column.
- wt_data  in  DATA_W  signed weight.
- in_valid  in  1  column present on row_new/row_d1/row_d2.
- in_ready  out  1  column accepted when in_valid && in_ready.
- row_new  in  DATA_W  current-row pixel.
- row_d1  in  DATA_W  pixel one row back.
- row_d2  in  DATA_W  pixel two rows back.
- out_data  out  DATA_W  signed result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse on the handshake of the last output of the frame.

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE.
  - Counters, window registers, pipeline data and valid bits, and out_data all cleared to 0.
  - out_valid=0, in_ready=0, busy=0, frame_done=0.
  - Kernel registers cleared to 0.
  - rst mid-frame aborts the frame; in-flight results are discarded.
- FSM:
  - IDLE: start latches img_width/img_height, clears col=row=0, goes to RUN.
  - RUN: accepts columns.
  - DONE: entered after the column at col=W-1, row=H-1 is accepted. Stays until the pipeline drains and last output handshakes. frame_done pulses on that handshake. start in DONE restarts like IDLE, same cycle as the drain if needed.
  - start during RUN is ignored.
- Pipeline enable: en = !out_valid || out_ready. All stages freeze when en=0. in_ready = en && state==RUN.
- Accept edge:
  - Per row r, shift in: w[r][0]<=w[r][1], w[r][1]<=w[r][2], w[r][2]<=pixel, with row_d2 feeding r=0 and row_new feeding r=2.
  - col increments, wrapping to 0 at W-1; row increments on that wrap.
  - The stage-0 valid tag is set iff col>=2 && row>=2, using pre-increment counter values.
- Latency: fixed 3 enabled edges from the accept edge (window registers -> 9 registered products -> adder tree + shift + saturate into out_data/out_valid).
- Arithmetic:
  - Products are signed 2*DATA_W.
  - Sum is 2*DATA_W+4 bits, no overflow possible.
  - The sum is arithmetic-right-shifted by FRAC_BITS (truncation toward -inf).
  - The result saturates to the signed DATA_W range.
- Kernel writes:
  - Accepted only in IDLE/DONE; ignored in RUN.
  - wt_addr>8 is ignored.
  - A write takes effect the next cycle.
- Boundaries:
  - Only (W-2)*(H-2) outputs are produced per frame.
  - Windows spanning a row wrap (col 0/1) are never emitted.
  - in_valid while in_ready=0 is not consumed.
  - out_data holds its value while out_valid && !out_ready.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: after saturation, negative results are replaced with 0 (ReLU fused into the output stage, no extra latency).
- Undefined: signed saturated results pass unchanged.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - KERNEL_TAPS=9;
  - a typedef for the kernel array;
  - the sum width constant;
  - a saturate function.
- One natural sub-module, conv3x3_adder_tree: 9 products -> registered sum.

Test Plan:
- Identity kernel (w4=256, others 0, FRAC_BITS=8), 4x4 frame with pixel=row*4+col -> exactly 4 outputs: 5, 6, 9, 10, then a frame_done pulse with the 4th.
- All weights=256, all pixels=1000 -> each output 9000. All pixels=4000 -> 36000 saturates to 32767. All pixels=-4000 -> -32768, or 0 with CONV_RELU_EN.
- Hold out_ready=0 for 5 cycles mid-frame -> in_ready drops, out_data is stable, no output is lost or duplicated, order is preserved.
- wt_we during RUN changing w4 -> ignored, outputs unchanged. wt_addr=12 in IDLE -> no kernel change.
- rst asserted mid-frame (after 7 columns) -> next cycle out_valid=0 and busy=0. A new start runs a clean frame with the correct 4 outputs.
- W=3, H=3 frame -> a single output after the 9th column, then frame_done. start pulsed during RUN -> ignored.
